// File: rtl/oled_pkg.sv
// Shared OLED definitions: panel geometry, RGB565 palette, peak-hold FSM states
// and the thermometer-word level decoder.
package oled_pkg;

    localparam int WIDTH      = 96;
    localparam int HEIGHT     = 64;
    localparam int NUM_PIXELS = WIDTH * HEIGHT;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLUE   = 16'h001F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    // Level = index of the highest set bit plus one; an all-zero word is level 0.
    function automatic logic [4:0] thermo_level(input logic [15:0] word);
        logic [4:0] lvl;
        lvl = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (word[i]) begin
                lvl = 5'(i + 1);
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/level_peak_tracker.sv
// Latches the displayed volume level once per frame and runs the peak-hold /
// peak-decay marker state machine. Everything advances only on frame_start.
module level_peak_tracker
    import oled_pkg::*;
#(
    parameter int HOLD_FRAMES  = 30,
    parameter int DECAY_FRAMES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] led_light,
    output logic [4:0]  disp_level,
    output logic [4:0]  peak
);

    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam int DECAY_W = $clog2(DECAY_FRAMES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_FRAMES);
    localparam logic [DECAY_W-1:0] DECAY_RELOAD = DECAY_W'(DECAY_FRAMES);

    peak_state_t         state_r, state_s;
    logic [4:0]          peak_r, peak_s;
    logic [4:0]          disp_level_r;
    logic [4:0]          level_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
    logic [DECAY_W-1:0]  decay_cnt_r, decay_cnt_s;

    // Next-state logic of the peak marker; holds every register outside frame_start.
    always_comb begin
        level_s     = thermo_level(led_light);
        state_s     = state_r;
        peak_s      = peak_r;
        hold_cnt_s  = hold_cnt_r;
        decay_cnt_s = decay_cnt_r;
        if (frame_start) begin
            case (state_r)
                IDLE: begin
                    if (level_s != 5'd0) begin
                        peak_s     = level_s;
                        hold_cnt_s = HOLD_RELOAD;
                        state_s    = HOLD;
                    end else begin
                        peak_s = 5'd0;
                    end
                end
                HOLD: begin
                    if (level_s >= peak_r) begin
                        peak_s     = level_s;
                        hold_cnt_s = HOLD_RELOAD;
                    end else if (hold_cnt_r <= HOLD_W'(1)) begin
                        // Hold period expired: start stepping the marker down.
                        hold_cnt_s  = '0;
                        decay_cnt_s = DECAY_RELOAD;
                        state_s     = DECAY;
                    end else begin
                        hold_cnt_s = hold_cnt_r - HOLD_W'(1);
                    end
                end
                DECAY: begin
                    if (level_s >= peak_r) begin
                        peak_s     = level_s;
                        hold_cnt_s = HOLD_RELOAD;
                        state_s    = HOLD;
                    end else if (decay_cnt_r <= DECAY_W'(1)) begin
                        decay_cnt_s = DECAY_RELOAD;
                        // peak_r > level_s here, so peak_r - 1 cannot underflow.
                        if ((peak_r - 5'd1) <= level_s) begin
                            peak_s = level_s;
                            if (level_s != 5'd0) begin
                                hold_cnt_s = HOLD_RELOAD;
                                state_s    = HOLD;
                            end else begin
                                hold_cnt_s  = '0;
                                decay_cnt_s = '0;
                                state_s     = IDLE;
                            end
                        end else begin
                            peak_s = peak_r - 5'd1;
                        end
                    end else begin
                        decay_cnt_s = decay_cnt_r - DECAY_W'(1);
                    end
                end
                default: begin
                    state_s     = IDLE;
                    peak_s      = 5'd0;
                    hold_cnt_s  = '0;
                    decay_cnt_s = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and the per-frame displayed level.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            peak_r       <= 5'd0;
            hold_cnt_r   <= '0;
            decay_cnt_r  <= '0;
            disp_level_r <= 5'd0;
        end else begin
            state_r     <= state_s;
            peak_r      <= peak_s;
            hold_cnt_r  <= hold_cnt_s;
            decay_cnt_r <= decay_cnt_s;
            if (frame_start) begin
                disp_level_r <= level_s;
            end else begin
                disp_level_r <= disp_level_r;
            end
        end
    end

    assign disp_level = disp_level_r;
    assign peak       = peak_r;

endmodule

// File: rtl/volume_bar_render.sv
// Renders the volume level as a 16-segment vertical bar with a peak marker.
// Frame boundaries are detected from the raster index wrapping back to 0.
module volume_bar_render
    import oled_pkg::*;
#(
    parameter int BAR_X0       = 40,
    parameter int BAR_W        = 16,
    parameter int HOLD_FRAMES  = 30,
    parameter int DECAY_FRAMES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic [15:0] led_light,
    output logic [15:0] pixel_data_out,
    output logic        frame_start
);

    logic [12:0] prev_index_r;
    logic        frame_start_r;
    logic [15:0] pixel_r;
    logic [4:0]  disp_level_s;
    logic [4:0]  peak_s;
    logic [6:0]  x_s;
    logic [6:0]  y_s;
    logic [4:0]  seg_s;
    logic        in_bar_s;
    logic [15:0] colour_s;

    level_peak_tracker #(
        .HOLD_FRAMES  (HOLD_FRAMES),
        .DECAY_FRAMES (DECAY_FRAMES)
    ) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start_r),
        .led_light   (led_light),
        .disp_level  (disp_level_s),
        .peak        (peak_s)
    );

    // Raster position, bar hit test and segment colour for the current index.
    always_comb begin
        x_s      = 7'(pixel_index % 13'(WIDTH));
        y_s      = 7'(pixel_index / 13'(WIDTH));
        // Segment k spans rows 61-3k..63-3k, i.e. k = (63 - y) / 3 for rows 13..60.
        seg_s    = 5'((7'd63 - y_s) / 7'd3);
        in_bar_s = (pixel_index < 13'(NUM_PIXELS)) &&
                   (x_s >= 7'(BAR_X0)) && (x_s < 7'(BAR_X0 + BAR_W)) &&
                   (y_s >= 7'd13) && (y_s <= 7'd60);
        colour_s = BLACK;
        if (!in_bar_s) begin
            colour_s = BLACK;
        end else if (seg_s <= disp_level_s) begin
            if (seg_s <= 5'd6) begin
                colour_s = GREEN;
            end else if (seg_s <= 5'd11) begin
                colour_s = YELLOW;
            end else begin
                colour_s = RED;
            end
        end else if ((seg_s == peak_s) && (peak_s > disp_level_s)) begin
            colour_s = WHITE;
        end else begin
            colour_s = BLACK;
        end
    end

    // Frame detect and registered pixel output.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_index_r  <= 13'd0;
            frame_start_r <= 1'b0;
            pixel_r       <= BLACK;
        end else begin
            prev_index_r  <= pixel_index;
            frame_start_r <= (pixel_index == 13'd0) && (prev_index_r != 13'd0);
            pixel_r       <= colour_s;
        end
    end

    assign pixel_data_out = pixel_r;
    assign frame_start    = frame_start_r;

endmodule

// File: tb/tb_volume_bar_render.sv
// Randomised scoreboard bench for volume_bar_render against a frame-level model.
module tb_volume_bar_render;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] pixel_index = 13'd0;
    logic [15:0] led_light = 16'h0000;
    logic [15:0] pixel_data_out;
    logic        frame_start;

    always #5 clock = ~clock;

    volume_bar_render dut (
        .clock          (clock),
        .reset          (reset),
        .pixel_index    (pixel_index),
        .led_light      (led_light),
        .pixel_data_out (pixel_data_out),
        .frame_start    (frame_start)
    );

    typedef struct {
        logic [15:0] pix;
        logic        fs;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: per-frame level/peak, mode 0 idle, 1 hold, 2 decay.
    int m_disp = 0, m_peak = 0, m_hold = 0, m_decay = 0, m_mode = 0;
    int m_prev_idx = 0;
    bit m_fs_pending = 0;

    function automatic int level_of(logic [15:0] w);
        int n = 0;
        int v = int'(w);
        while (v != 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic logic [15:0] model_colour(int idx);
        int x, y;
        if (idx >= 6144) return 16'h0000;
        x = idx % 96;
        y = idx / 96;
        if (x < 40 || x > 55) return 16'h0000;
        for (int k = 1; k <= 16; k++) begin
            if (y >= 61 - 3 * k && y <= 63 - 3 * k) begin
                if (k <= m_disp) return (k <= 6) ? 16'h07E0 : (k <= 11) ? 16'hFFE0 : 16'hF800;
                if (k == m_peak && m_peak > m_disp) return 16'hFFFF;
                return 16'h0000;
            end
        end
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_peak = 0; m_hold = 0; m_decay = 0; m_mode = 0;
        m_prev_idx = 0; m_fs_pending = 0;
    endtask

    task automatic model_frame(int lvl);
        m_disp = lvl;
        case (m_mode)
            0: if (lvl > 0) begin m_peak = lvl; m_hold = 30; m_mode = 1; end
            1: begin
                if (lvl >= m_peak) begin
                    m_peak = lvl; m_hold = 30;
                end else begin
                    m_hold--;
                    if (m_hold == 0) begin m_mode = 2; m_decay = 4; end
                end
            end
            default: begin
                if (lvl >= m_peak) begin
                    m_peak = lvl; m_hold = 30; m_mode = 1;
                end else begin
                    m_decay--;
                    if (m_decay == 0) begin
                        m_peak--;
                        m_decay = 4;
                        if (m_peak <= lvl) begin
                            m_peak = lvl;
                            m_mode = (lvl > 0) ? 1 : 0;
                            m_hold = 30;
                        end
                    end
                end
            end
        endcase
    endtask

    // One cycle of stimulus; the expected response is queued for the monitor.
    task automatic drive(int idx, logic [15:0] led, bit rst);
        exp_t e;
        @(negedge clock);
        pixel_index = 13'(idx);
        led_light   = led;
        reset       = rst;
        if (rst) begin
            model_reset();
            e.pix = 16'h0000;
            e.fs  = 1'b0;
        end else begin
            e.pix = model_colour(idx);
            e.fs  = (idx == 0) && (m_prev_idx != 0);
            if (m_fs_pending) model_frame(level_of(led));
            m_fs_pending = e.fs;
            m_prev_idx   = idx;
        end
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic short_frame(logic [15:0] led);
        drive(0, led, 1'b0);
        for (int y = 10; y < 64; y++) drive(y * 96 + int'($urandom_range(38, 57)), led, 1'b0);
        for (int i = 0; i < 4; i++) drive(int'($urandom_range(1, 8191)), led, 1'b0);
    endtask

    task automatic full_frame(logic [15:0] led_a, logic [15:0] led_b, int switch_at);
        for (int i = 0; i < 6144; i++) drive(i, (i < switch_at) ? led_a : led_b, 1'b0);
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Monitor: the output one cycle after each driven index is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_data_out !== e.pix) begin
                    errors++;
                    $display("FAIL pixel idx=%0d x=%0d y=%0d got=%h expected=%h",
                             e.idx, e.idx % 96, e.idx / 96, pixel_data_out, e.pix);
                end
                checks++;
                if (frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL frame_start idx=%0d got=%b expected=%b", e.idx, frame_start, e.fs);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [15:0] rled;

        // Power-up reset with full volume applied.
        for (int i = 0; i < 4; i++) drive(int'($urandom_range(0, 8191)), 16'hFFFF, 1'b1);
        short_frame(16'hFFFF);
        short_frame(16'hFFFF);

        // Reset in the middle of a frame, then the rest of the frame stays black.
        drive(0, 16'hFFFF, 1'b0);
        for (int y = 10; y < 40; y++) drive(y * 96 + 45, 16'hFFFF, 1'b0);
        for (int y = 40; y < 43; y++) drive(y * 96 + 45, 16'hFFFF, 1'b1);
        for (int y = 43; y < 64; y++) drive(y * 96 + 45, 16'hFFFF, 1'b0);
        check_int("peak_after_reset", int'(dut.u_tracker.peak_r), 0);
        check_int("state_after_reset", int'(dut.u_tracker.state_r), int'(oled_pkg::IDLE));

        // Six-segment level over a full scan.
        short_frame(16'h003F);
        full_frame(16'h003F, 16'h003F, 6144);

        // Full-scale burst, then silence: hold, then decay down to peak 10.
        short_frame(16'hFFFF);
        guard = 0;
        while (!(m_mode == 2 && m_peak == 10) && guard < 200) begin
            short_frame(16'h0000);
            guard++;
        end
        check_int("reach_decay_peak10", int'(m_mode == 2 && m_peak == 10), 1);

        // Level 12 during decay re-arms the hold at 12.
        short_frame(16'h0FFF);
        check_int("rearm_peak", int'(dut.u_tracker.peak_r), 12);
        check_int("rearm_state", int'(dut.u_tracker.state_r), int'(oled_pkg::HOLD));
        check_int("rearm_hold_cnt", int'(dut.u_tracker.hold_cnt_r), 30);

        // Silence until the marker has decayed all the way.
        guard = 0;
        while (m_mode != 0 && guard < 200) begin
            short_frame(16'h0000);
            guard++;
        end
        check_int("model_idle_reached", int'(m_mode == 0), 1);
        check_int("dut_idle_state", int'(dut.u_tracker.state_r), int'(oled_pkg::IDLE));
        check_int("dut_idle_peak", int'(dut.u_tracker.peak_r), 0);

        // Volume jumps mid-frame: only the next frame reflects it.
        full_frame(16'h0001, 16'hFFFF, 3000);
        short_frame(16'hFFFF);

        // Out-of-range indices and the return to 0.
        drive(6150, 16'hFFFF, 1'b0);
        drive(8191, 16'hFFFF, 1'b0);
        drive(0, 16'hFFFF, 1'b0);
        drive(0, 16'hFFFF, 1'b0);
        drive(0, 16'hFFFF, 1'b0);
        drive(5, 16'hFFFF, 1'b0);

        // Random volumes, both thermometer and arbitrary words.
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 1) == 1) rled = 16'hFFFF >> $urandom_range(0, 16);
            else rled = 16'($urandom);
            short_frame(rled);
        end

        repeat (3) @(negedge clock);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
